// File: rtl/elevator_request_panel.sv
// Request side of the elevator controller: synchronizes and debounces car/hall
// buttons, holds pending calls as lamps, and serves floor-relative request flags.
module elevator_request_panel #(
  parameter int N           = 10,
  parameter int SYNC_STAGES = 2,
  parameter int DEB         = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] button_in,
  input  logic [N-1:0] button_out,
  input  logic [N-1:0] current_floor,
  input  logic         open,
  output logic [N-1:0] lamp_in,
  output logic [N-1:0] lamp_out,
  output logic         request_i,
  output logic         request_j_gt_i,
  output logic         request_j_lt_i,
  output logic         floor_err
);

  localparam int B  = 2 * N;
  localparam int CW = $clog2(DEB + 1);

  // Car buttons occupy bits [N-1:0], hall buttons bits [2N-1:N].
  logic [B-1:0]  w_raw;
  logic [B-1:0]  w_s;
  logic [B-1:0]  w_acc;
  logic [B-1:0]  r_sync [SYNC_STAGES];
  logic [CW-1:0] r_cnt  [B];
  logic          w_floor_err;
  logic [N-1:0]  w_clr;
  logic [N-1:0]  w_pend;
  logic [N-1:0]  w_above;
  logic [N-1:0]  w_below;

  assign w_raw = {button_out, button_in};
  assign w_s   = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments make every stage sample the previous
      // stage's old value, so the chain really is SYNC_STAGES flops deep.
      r_sync[0] <= w_raw;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  // NOTE: the counter array is real state whose value must be known after
  // reset (a partial debounce is discarded), so it is reset like any flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < B; b++) r_cnt[b] <= '0;
    end else begin
      for (int b = 0; b < B; b++) begin
        if (!w_s[b])                    r_cnt[b] <= '0;
        else if (r_cnt[b] != CW'(DEB))  r_cnt[b] <= r_cnt[b] + 1'b1;
      end
    end
  end

  // Accept only on the step into saturation, so a held button fires once.
  always_comb begin
    w_acc = '0;
    for (int b = 0; b < B; b++) w_acc[b] = w_s[b] && (r_cnt[b] == CW'(DEB - 1));
  end

  assign w_floor_err = !$onehot(current_floor);
  assign w_clr       = {N{open & ~w_floor_err}} & current_floor;
  assign w_pend      = lamp_in | lamp_out;

  // w_above[j]: the car sits below floor j; w_below[j]: the car sits above it.
  always_comb begin
    // NOTE: defaults first keep this block free of inferred latches.
    w_above = '0;
    w_below = '0;
    for (int j = 1; j < N; j++)      w_above[j] = w_above[j-1] | current_floor[j-1];
    for (int j = N - 2; j >= 0; j--) w_below[j] = w_below[j+1] | current_floor[j+1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lamp_in        <= '0;
      lamp_out       <= '0;
      request_i      <= 1'b0;
      request_j_gt_i <= 1'b0;
      request_j_lt_i <= 1'b0;
      floor_err      <= 1'b0;
    end else begin
      lamp_in   <= (lamp_in  | w_acc[N-1:0]) & ~w_clr;
      lamp_out  <= (lamp_out | w_acc[B-1:N]) & ~w_clr;
      floor_err <= w_floor_err;
      if (w_floor_err) begin
        request_i      <= 1'b0;
        request_j_gt_i <= 1'b0;
        request_j_lt_i <= 1'b0;
      end else begin
        request_i      <= |(w_pend & current_floor);
        request_j_gt_i <= |(w_pend & w_above);
        request_j_lt_i <= |(w_pend & w_below);
      end
    end
  end

endmodule

// File: tb/tb_elevator_request_panel.sv
// Directed bench for elevator_request_panel: expected output snapshots are queued
// as stimulus is applied and compared against the DUT when they fall due.
module tb_elevator_request_panel;

  localparam int N = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] button_in, button_out, current_floor;
  logic         open;
  logic [N-1:0] lamp_in, lamp_out;
  logic         request_i, request_j_gt_i, request_j_lt_i, floor_err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string        tag;
    logic [N-1:0] lin;
    logic [N-1:0] lout;
    logic         ri, gt, lt, fe;
  } exp_t;

  exp_t sb[$];

  elevator_request_panel #(.N(N), .SYNC_STAGES(2), .DEB(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .button_in      (button_in),
    .button_out     (button_out),
    .current_floor  (current_floor),
    .open           (open),
    .lamp_in        (lamp_in),
    .lamp_out       (lamp_out),
    .request_i      (request_i),
    .request_j_gt_i (request_j_gt_i),
    .request_j_lt_i (request_j_lt_i),
    .floor_err      (floor_err)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] fl(input int k);
    return N'(1) << k;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [N-1:0] lin, input logic [N-1:0] lout,
                         input logic ri, input logic gt, input logic lt, input logic fe);
    exp_t e;
    e.tag = tag; e.lin = lin; e.lout = lout;
    e.ri = ri; e.gt = gt; e.lt = lt; e.fe = fe;
    sb.push_back(e);
  endtask

  task automatic sb_check();
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_empty observed=0 entries expected>=1");
    end else begin
      e = sb.pop_front();
      check({e.tag, ".lamp_in"},   lamp_in,                 e.lin);
      check({e.tag, ".lamp_out"},  lamp_out,                e.lout);
      check({e.tag, ".req_i"},     N'(request_i),           N'(e.ri));
      check({e.tag, ".req_gt"},    N'(request_j_gt_i),      N'(e.gt));
      check({e.tag, ".req_lt"},    N'(request_j_lt_i),      N'(e.lt));
      check({e.tag, ".floor_err"}, N'(floor_err),           N'(e.fe));
    end
  endtask

  initial begin
    rst = 1'b1; button_in = '0; button_out = '0; open = 1'b0;
    current_floor = fl(2);
    repeat (3) @(posedge clk);
    #1;
    sb_push("reset", '0, '0, 0, 0, 0, 0); sb_check();
    rst = 1'b0;

    // Reset in the middle of a debounce discards it; the press restarts.
    button_in[3] = 1'b1;
    tick(4);
    rst = 1'b1; #1;
    sb_push("rst_mid", '0, '0, 0, 0, 0, 0); sb_check();
    tick(2);
    rst = 1'b0;
    sb_push("rst_restart_e5", '0, '0, 0, 0, 0, 0); tick(5); sb_check();
    sb_push("lamp3_e6", fl(3), '0, 0, 0, 0, 0);    tick(1); sb_check();
    sb_push("req3_e7",  fl(3), '0, 0, 1, 0, 0);    tick(1); sb_check();
    button_in[3] = 1'b0; current_floor = fl(3); open = 1'b1;
    sb_push("clr3",     '0, '0, 1, 0, 0, 0);       tick(1); sb_check();
    open = 1'b0; current_floor = fl(2);
    sb_push("clr3_req", '0, '0, 0, 0, 0, 0);       tick(1); sb_check();
    tick(3);

    // Three-cycle hall pulse is one short of acceptance.
    button_out[7] = 1'b1; tick(3); button_out[7] = 1'b0;
    sb_push("pulse3", '0, '0, 0, 0, 0, 0); tick(7); sb_check();

    // Held hall call: lamp after edge 6, request after edge 7.
    button_out[7] = 1'b1;
    sb_push("hold_e5", '0, '0,    0, 0, 0, 0); tick(5); sb_check();
    sb_push("hold_e6", '0, fl(7), 0, 0, 0, 0); tick(1); sb_check();
    sb_push("hold_e7", '0, fl(7), 0, 1, 0, 0); tick(1); sb_check();
    tick(3); button_out[7] = 1'b0; tick(3);

    // Service clear at floor 5; a held button does not re-latch.
    button_in[5] = 1'b1;
    sb_push("in5_e6", fl(5), fl(7), 0, 1, 0, 0); tick(6); sb_check();
    current_floor = fl(5); open = 1'b1;
    sb_push("clr5", '0, fl(7), 1, 1, 0, 0);      tick(1); sb_check();
    open = 1'b0;
    sb_push("clr5_req", '0, fl(7), 0, 1, 0, 0);  tick(1); sb_check();
    sb_push("held5_norelatch", '0, fl(7), 0, 1, 0, 0); tick(5); sb_check();
    button_in[5] = 1'b0; tick(4); button_in[5] = 1'b1;
    sb_push("repress5", fl(5), fl(7), 0, 1, 0, 0);     tick(6); sb_check();
    sb_push("repress5_req", fl(5), fl(7), 1, 1, 0, 0); tick(1); sb_check();
    button_in[5] = 1'b0; open = 1'b1;
    sb_push("clr5b", '0, fl(7), 1, 1, 0, 0);           tick(1); sb_check();
    open = 1'b0;
    sb_push("idle5", '0, fl(7), 0, 1, 0, 0);           tick(3); sb_check();

    // Accept and clear on the same edge at floor 4; floor 8 still latches.
    current_floor = fl(4); button_in[4] = 1'b1; button_in[8] = 1'b1;
    tick(5); open = 1'b1;
    sb_push("simul", fl(8), fl(7), 0, 1, 0, 0);      tick(1); sb_check();
    open = 1'b0;
    sb_push("simul_req", fl(8), fl(7), 0, 1, 0, 0);  tick(1); sb_check();
    sb_push("simul_hold", fl(8), fl(7), 0, 1, 0, 0); tick(4); sb_check();
    button_in[4] = 1'b0; button_in[8] = 1'b0; tick(3);

    // Boundary floors with calls at 0 and 9.
    button_in[0] = 1'b1; button_out[9] = 1'b1;
    sb_push("bnd_latch", fl(0) | fl(8), fl(7) | fl(9), 0, 1, 0, 0); tick(6); sb_check();
    button_in[0] = 1'b0; button_out[9] = 1'b0; current_floor = fl(0);
    sb_push("bottom", fl(0) | fl(8), fl(7) | fl(9), 1, 1, 0, 0); tick(1); sb_check();
    current_floor = fl(9);
    sb_push("top",    fl(0) | fl(8), fl(7) | fl(9), 1, 0, 1, 0); tick(1); sb_check();
    tick(2);

    // Invalid floor code: flags forced low, clears suppressed, accepts still latch.
    current_floor = '0; open = 1'b1;
    sb_push("ferr_zero", fl(0) | fl(8), fl(7) | fl(9), 0, 0, 0, 1); tick(1); sb_check();
    current_floor = fl(2) | fl(3); button_in[2] = 1'b1;
    sb_push("ferr_two", fl(0) | fl(8), fl(7) | fl(9), 0, 0, 0, 1);  tick(1); sb_check();
    sb_push("ferr_accept", fl(0) | fl(2) | fl(8), fl(7) | fl(9), 0, 0, 0, 1); tick(5); sb_check();
    current_floor = fl(2); open = 1'b0;
    sb_push("ferr_recover", fl(0) | fl(2) | fl(8), fl(7) | fl(9), 1, 1, 1, 0); tick(1); sb_check();
    open = 1'b1;
    sb_push("clr2", fl(0) | fl(8), fl(7) | fl(9), 1, 1, 1, 0);      tick(1); sb_check();
    open = 1'b0; button_in[2] = 1'b0;
    sb_push("clr2_req", fl(0) | fl(8), fl(7) | fl(9), 0, 1, 1, 0);  tick(1); sb_check();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
